// File: rtl/dmem_sb_pkg.sv
// Shared types and lane helpers for the data-memory responder and its store buffer.
package arm_mem_pkg;

  localparam int IDX_W = 30;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } drain_state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [31:0]      data;
    logic [3:0]       mask;
  } sb_entry_t;

  function automatic logic [3:0] lane_mask(input logic byte_acc, input logic [1:0] lane);
    return byte_acc ? (4'b0001 << lane) : 4'b1111;
  endfunction

  // Replace the lanes of base selected by mask with the matching lanes of data.
  function automatic logic [31:0] lane_merge(input logic [31:0] base,
                                             input logic [31:0] data,
                                             input logic [3:0]  mask);
    logic [31:0] r;
    for (int l = 0; l < 4; l++) begin
      r[8*l +: 8] = mask[l] ? data[8*l +: 8] : base[8*l +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_sb_store_buffer.sv
// Circular store buffer: posts stores, hands the oldest entry to the drain,
// and overlays pending stores onto a load word lane by lane.
module store_buffer
  import arm_mem_pkg::*;
#(
  parameter int SB_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq,
  input  sb_entry_t        enq_entry,
  input  logic             pop,
  output sb_entry_t        head_entry,
  output logic             full,
  output logic             one_left,
  output logic             empty,
  input  logic [IDX_W-1:0] fwd_idx,
  input  logic [31:0]      fwd_base,
  output logic [31:0]      fwd_word
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t     slots [SB_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  assign full       = (count == CW'(SB_DEPTH));
  assign one_left   = (count == CW'(1));
  assign head_entry = slots[head];

  always_comb begin
    count_next = count;
    if (enq && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !enq) begin
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      empty <= 1'b1;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (pop) head <= head + PW'(1);
      count <= count_next;
      empty <= (count_next == '0);
    end
  end

  // When full with a simultaneous pop, tail equals head: the head is read out
  // for the commit at this same edge, so overwriting its slot is safe.
  always_ff @(posedge clk) begin
    if (enq) slots[tail] <= enq_entry;
  end

  // Walk oldest to newest so the youngest matching store owns each lane.
  always_comb begin
    fwd_word = fwd_base;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if ((CW'(i) < count) && (slots[head + PW'(i)].idx == fwd_idx)) begin
        fwd_word = lane_merge(fwd_word, slots[head + PW'(i)].data, slots[head + PW'(i)].mask);
      end
    end
  end

endmodule

// File: rtl/dmem_sb.sv
// Data-memory responder: posted stores drain into a slow-write word array while
// loads are answered combinationally with byte-granular store forwarding.
module dmem_sb
  import arm_mem_pkg::*;
#(
  parameter int DEPTH        = 64,
  parameter int SB_DEPTH     = 4,
  parameter int WRITE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        be,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        stall,
  output logic        sb_empty,
  output logic        dbg_state
);

  localparam int IW = $clog2(DEPTH);
  localparam int WW = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;

  logic [31:0]      mem [DEPTH];
  drain_state_t     state;
  logic [WW-1:0]    w;
  logic             full;
  logic             one_left;
  logic             pop;
  logic             enq;
  sb_entry_t        head;
  sb_entry_t        new_entry;
  logic [IDX_W-1:0] a_idx;
  logic [31:0]      arr_word;
  logic [31:0]      fwd_word;
  logic [7:0]       lane_byte;
  logic             unused_bits;

  assign a_idx       = IDX_W'(a[IW+1:2]);
  assign arr_word    = mem[a_idx[IW-1:0]];
  assign unused_bits = ^{a[31:IW+2], head.idx[IDX_W-1:IW]};

  assign new_entry = '{idx:  a_idx,
                       data: be ? {4{wd[7:0]}} : wd,
                       mask: lane_mask(be, a[1:0])};

  // Handshake: a store is taken at a rising edge when we=1 and stall=0; while
  // stall=1 the core holds we/a/wd/be steady. A pop frees a slot in the same
  // cycle, so a stalled store always gets in on the next pop cycle.
  assign pop   = (state == WRITE) && (w == WW'(WRITE_CYCLES - 1));
  assign enq   = we && (!full || pop);
  assign stall = we && full && !pop;

  assign dbg_state = state;

  store_buffer #(
    .SB_DEPTH(SB_DEPTH)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .enq       (enq),
    .enq_entry (new_entry),
    .pop       (pop),
    .head_entry(head),
    .full      (full),
    .one_left  (one_left),
    .empty     (sb_empty),
    .fwd_idx   (a_idx),
    .fwd_base  (arr_word),
    .fwd_word  (fwd_word)
  );

  // A store arriving while idle starts the drain at the same edge it is posted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      w     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enq || !sb_empty) begin
            state <= WRITE;
            w     <= '0;
          end
        end
        WRITE: begin
          if (pop) begin
            w     <= '0;
            state <= (!one_left || enq) ? WRITE : IDLE;
          end else begin
            w <= w + WW'(1);
          end
        end
        default: begin
          state <= IDLE;
          w     <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      mem[head.idx[IW-1:0]] <= lane_merge(mem[head.idx[IW-1:0]], head.data, head.mask);
    end
  end

  always_comb begin
    case (a[1:0])
      2'd1:    lane_byte = fwd_word[15:8];
      2'd2:    lane_byte = fwd_word[23:16];
      2'd3:    lane_byte = fwd_word[31:24];
      default: lane_byte = fwd_word[7:0];
    endcase
    rd = be ? {24'b0, lane_byte} : fwd_word;
  end

endmodule

// File: tb/tb_dmem_sb.sv
// Bench for dmem_sb: directed and random loads/stores against a model that tracks
// the memory image as seen by loads plus the commit cycle of every posted store.
module tb_dmem_sb;

  localparam int DEPTH    = 64;
  localparam int SB_DEPTH = 4;
  localparam int WC       = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic        be;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        stall;
  logic        sb_empty;
  logic        dbg_state;

  dmem_sb #(
    .DEPTH(DEPTH), .SB_DEPTH(SB_DEPTH), .WRITE_CYCLES(WC)
  ) dut (
    .clk(clk), .reset(reset), .we(we), .be(be), .a(a), .wd(wd),
    .rd(rd), .stall(stall), .sb_empty(sb_empty), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete, required finish");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  typedef struct {
    int          idx;
    logic [31:0] data;
    logic [3:0]  mask;
    int          commit;
  } pend_t;

  pend_t       pq[$];
  logic [31:0] vis_mem [DEPTH];
  logic [31:0] cm      [DEPTH];
  logic [31:0] exp_q[$];
  int          last_commit;
  int          cyc;
  int          checks;
  int          errors;
  logic        exp_stall;
  logic        accepted;

  function automatic logic [31:0] apply(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] mask);
    logic [31:0] r = old;
    for (int l = 0; l < 4; l++) if (mask[l]) r[8*l +: 8] = data[8*l +: 8];
    return r;
  endfunction

  function automatic int widx(input logic [31:0] addr);
    return int'((addr >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] addr, input logic b);
    logic [31:0] word = vis_mem[widx(addr)];
    if (b) return (word >> (8 * addr[1:0])) & 32'hFF;
    return word;
  endfunction

  // ---------------- scoreboard ----------------
  function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d, a=%h)", tag, obs, exp, cyc, a);
    end
  endfunction

  function automatic void check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endfunction

  task automatic prune();
    while (pq.size() > 0 && pq[0].commit < cyc) begin
      cm[pq[0].idx] = apply(cm[pq[0].idx], pq[0].data, pq[0].mask);
      void'(pq.pop_front());
    end
  endtask

  task automatic cycle_check();
    logic mfull;
    logic mpop;
    prune();
    mfull     = (pq.size() == SB_DEPTH);
    mpop      = (pq.size() > 0) && (pq[0].commit == cyc);
    exp_stall = we && mfull && !mpop;
    check_bit("stall", stall, exp_stall);
    check_bit("sb_empty", sb_empty, pq.size() == 0);
    check_bit("drain_busy", dbg_state, pq.size() != 0);
    if (!we) begin
      exp_q.push_back(model_rd(a, be));
      check("rd", rd, exp_q.pop_front());
    end
  endtask

  task automatic accept();
    pend_t e;
    e.idx    = widx(a);
    e.mask   = be ? (4'b0001 << a[1:0]) : 4'b1111;
    e.data   = be ? ({24'b0, wd[7:0]} << (8 * a[1:0])) : wd;
    e.commit = (cyc + WC > last_commit + WC) ? cyc + WC : last_commit + WC;
    last_commit  = e.commit;
    vis_mem[e.idx] = apply(vis_mem[e.idx], e.data, e.mask);
    pq.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    accepted = we && !exp_stall;
    if (accepted) accept();
    cyc++;
    #1;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic b);
    we = 1'b1; be = b; a = addr; wd = data;
    for (int n = 0; n < 64; n++) begin
      tick();
      if (accepted) break;
    end
    if (!accepted) check_bit("store_accept_timeout", 1'b0, 1'b1);
    we = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic b);
    we = 1'b0; be = b; a = addr; wd = $urandom;
    tick();
  endtask

  task automatic do_idle(input int n);
    for (int k = 0; k < n; k++) begin
      we = 1'b0; be = 1'($urandom_range(0, 1)); a = $urandom; wd = $urandom;
      tick();
    end
  endtask

  task automatic mid_reset();
    @(negedge clk);
    cycle_check();
    #1 reset = 1'b1; we = 1'b1;
    #1;
    check_bit("async_rst_sb_empty", sb_empty, 1'b1);
    check_bit("async_rst_stall", stall, 1'b0);
    check_bit("async_rst_state", dbg_state, 1'b0);
    we = 1'b0; reset = 1'b0;
    pq.delete();
    last_commit = -1000;
    for (int i = 0; i < DEPTH; i++) vis_mem[i] = cm[i];
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    checks = 0; errors = 0; cyc = 0; last_commit = -1000;
    reset = 1'b1; we = 1'b0; be = 1'b0; a = '0; wd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      vis_mem[i] = 'x;
      cm[i]      = 'x;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_bit("reset_sb_empty", sb_empty, 1'b1);
    check_bit("reset_stall", stall, 1'b0);
    check_bit("reset_state", dbg_state, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Give every word a known value; this also runs the buffer full and wraps its pointers.
    for (int i = 0; i < DEPTH; i++) do_store(32'(i * 4), $urandom, 1'b0);
    do_idle(12);

    // Word round trip: forwarded first, then from the array.
    do_store(32'h10, 32'hDEADBEEF, 1'b0);
    do_load(32'h10, 1'b0);
    check("roundtrip_forward", rd, 32'hDEADBEEF);
    do_idle(3);
    do_load(32'h10, 1'b0);
    check("roundtrip_array", rd, 32'hDEADBEEF);
    check_bit("roundtrip_sb_empty", sb_empty, 1'b1);

    // Byte merge over an array word.
    do_store(32'h10, 32'h11223344, 1'b0);
    do_idle(4);
    do_store(32'h11, 32'h000000AA, 1'b1);
    do_store(32'h13, 32'hFFFFFFBB, 1'b1);
    do_load(32'h10, 1'b0);
    check("byte_merge_word", rd, 32'hBB22AA44);
    do_load(32'h13, 1'b1);
    check("byte_merge_ldrb", rd, 32'h000000BB);
    do_idle(8);
    do_load(32'h10, 1'b0);
    check("byte_merge_committed", rd, 32'hBB22AA44);

    // Newest store to the same word wins, before and after drain.
    do_store(32'h20, 32'h1, 1'b0);
    do_store(32'h20, 32'h2, 1'b0);
    do_load(32'h20, 1'b0);
    check("newest_wins_pending", rd, 32'h2);
    do_idle(8);
    do_load(32'h20, 1'b0);
    check("newest_wins_drained", rd, 32'h2);

    // Burst long enough to fill the buffer and stall on non-pop cycles.
    for (int i = 0; i < 8; i++) do_store(32'h40 + 32'(4 * i), $urandom, 1'b0);
    do_idle(20);
    for (int i = 0; i < 8; i++) do_load(32'h40 + 32'(4 * i), 1'b0);

    // Address aliasing modulo DEPTH words.
    do_store(32'h100, 32'hCAFEF00D, 1'b0);
    do_idle(6);
    do_load(32'h000, 1'b0);
    check("wrap_alias", rd, 32'hCAFEF00D);
    do_store(32'hFFFFFF05, 32'h0000005A, 1'b1);
    do_load(32'h00000004, 1'b0);
    do_load(32'h00000005, 1'b1);
    check("wrap_alias_byte", rd, 32'h0000005A);

    // Random mix of word/byte stores, loads and idle cycles.
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 3))
        0: do_store($urandom, $urandom, 1'b0);
        1: do_store($urandom_range(0, 4 * DEPTH - 1), $urandom, 1'b1);
        2: do_load($urandom, 1'($urandom_range(0, 1)));
        default: do_idle(1);
      endcase
    end
    do_idle(12);

    // Asynchronous reset with entries pending mid-drain.
    do_store(32'h80, 32'hA0A0A0A0, 1'b0);
    do_store(32'h84, 32'hA1A1A1A1, 1'b0);
    do_store(32'h88, 32'hA2A2A2A2, 1'b0);
    do_store(32'h8C, 32'hA3A3A3A3, 1'b0);
    mid_reset();
    for (int i = 0; i < 4; i++) do_load(32'h80 + 32'(4 * i), 1'b0);
    do_store(32'h90, 32'h12345678, 1'b0);
    do_idle(4);
    do_load(32'h90, 1'b0);
    check("post_reset_store", rd, 32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
